// File: rtl/slice_pkg.sv
// Shared types and default geometry for the slice frame loader.
package slice_pkg;

    localparam int unsigned DEPTH_DEF = 10;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned WIN_DEF   = 3;

    typedef enum logic {FILL, HOLD} loader_state_e;

    typedef logic [WIDTH_DEF-1:0] elem_t;

endpackage

// File: rtl/slice_window_sel.sv
// Clamped WIN-entry slice of a DEPTH-entry frame; purely combinational.
module slice_window_sel #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WIN   = 3
) (
    input  logic [WIDTH-1:0]         frame_i [0:DEPTH-1],
    input  logic [$clog2(DEPTH)-1:0] win_off_i,
    output logic [WIDTH-1:0]         win_o   [0:WIN-1]
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    // One extra bit so off_c + k can never wrap.
    localparam logic [IdxW:0] MaxOff = (IdxW+1)'(DEPTH - WIN);

    logic [IdxW:0] off_ext;
    logic [IdxW:0] off_c;

    // Clamp the offset so the window never reaches past the last entry, then slice.
    always_comb begin
        off_ext = {1'b0, win_off_i};
        off_c   = (off_ext > MaxOff) ? MaxOff : off_ext;
        for (int k = 0; k < WIN; k++) begin
            win_o[k] = frame_i[off_c + (IdxW+1)'(k)];
        end
    end

endmodule

// File: rtl/slice_frame_loader.sv
// Collects DEPTH beats into a frame, then holds it (plus reversed copy, window and
// equality-vs-previous flag) under a valid/ready handshake.
module slice_frame_loader import slice_pkg::*; #(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned WIN   = WIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic [$clog2(DEPTH)-1:0] win_off_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_frame_o     [0:DEPTH-1],
    output logic [WIDTH-1:0]         out_frame_rev_o [DEPTH-1:0],
    output logic [WIDTH-1:0]         out_win_o       [0:WIN-1],
    output logic                     out_match_o
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

    loader_state_e    state_q;
    logic [WIDTH-1:0] frame_q [0:DEPTH-1];
    logic [WIDTH-1:0] prev_q  [0:DEPTH-1];
    logic [IdxW-1:0]  wr_idx_q;
    logic             prev_valid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             same;

    // Fill/hold controller; the handshake edge itself never accepts a beat because
    // in_ready_q is still low on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            prev_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                frame_q[i] <= '0;
                prev_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        frame_q[wr_idx_q] <= in_data_i;
                        if (wr_idx_q == LastIdx) begin
                            wr_idx_q    <= '0;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + IdxW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        prev_q       <= frame_q;
                        prev_valid_q <= 1'b1;
                        state_q      <= FILL;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Frame views and equality flag; an X entry takes the else branch and clears same.
    always_comb begin
        same = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            out_frame_rev_o[DEPTH-1-i] = frame_q[i];
            if (frame_q[i] == prev_q[i]) begin
                same = same;
            end else begin
                same = 1'b0;
            end
        end
        out_match_o = out_valid_q & prev_valid_q & same;
    end

    assign out_frame_o = frame_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;

    slice_window_sel #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .WIN   (WIN)
    ) u_win (
        .frame_i   (frame_q),
        .win_off_i (win_off_i),
        .win_o     (out_win_o)
    );

endmodule

// File: tb/tb_slice_frame_loader.sv
// Directed bench for slice_frame_loader: stimulus pushes expected frames into a
// scoreboard, a monitor pops and compares when out_valid rises.
module tb_slice_frame_loader;

    localparam int unsigned DEPTH = 10;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WIN   = 3;
    localparam int unsigned IdxW  = $clog2(DEPTH);

    typedef logic [DEPTH*WIDTH-1:0] frame_vec_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic [IdxW-1:0]  win_off   = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_match;
    logic [WIDTH-1:0] out_frame     [0:DEPTH-1];
    logic [WIDTH-1:0] out_frame_rev [DEPTH-1:0];
    logic [WIDTH-1:0] out_win       [0:WIN-1];

    int vectors     = 0;
    int miscompares = 0;

    frame_vec_t exp_frame_q [$];
    logic       exp_match_q [$];

    always #5 clk = ~clk;

    slice_frame_loader #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .WIN   (WIN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_data_i       (in_data),
        .win_off_i       (win_off),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_frame_o     (out_frame),
        .out_frame_rev_o (out_frame_rev),
        .out_win_o       (out_win),
        .out_match_o     (out_match)
    );

    task automatic chk(input string name, input frame_vec_t act, input frame_vec_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic frame_vec_t cur_frame();
        frame_vec_t v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = out_frame[i];
        return v;
    endfunction

    // Reversed view re-ordered back to ascending so it compares against the same model.
    function automatic frame_vec_t cur_rev();
        frame_vec_t v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = out_frame_rev[DEPTH-1-i];
        return v;
    endfunction

    function automatic frame_vec_t cur_win();
        frame_vec_t v = '0;
        for (int k = 0; k < WIN; k++) v[k*WIDTH +: WIDTH] = out_win[k];
        return v;
    endfunction

    function automatic frame_vec_t ramp(input logic [WIDTH-1:0] base);
        frame_vec_t v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        return v;
    endfunction

    function automatic frame_vec_t fill(input logic [WIDTH-1:0] val);
        frame_vec_t v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = val;
        return v;
    endfunction

    // Called at a negedge; beat is accepted on the following posedge.
    task automatic send_beat(input logic [WIDTH-1:0] d);
        chk("in_ready_fill", frame_vec_t'(in_ready), frame_vec_t'(1'b1));
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic send_frame(input frame_vec_t f, input bit gapped, input logic exp_m);
        exp_frame_q.push_back(f);
        exp_match_q.push_back(exp_m);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("ov_before_last", frame_vec_t'(out_valid), '0);
            send_beat(f[i*WIDTH +: WIDTH]);
            if (gapped && i != DEPTH - 1) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk("ov_after_last", frame_vec_t'(out_valid), frame_vec_t'(1'b1));
        chk("ir_after_last", frame_vec_t'(in_ready), '0);
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ov_after_hs", frame_vec_t'(out_valid), '0);
        chk("ir_after_hs", frame_vec_t'(in_ready), frame_vec_t'(1'b1));
        chk("match_gated", frame_vec_t'(out_match), '0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_in_ready", frame_vec_t'(in_ready), '0);
        chk("rst_out_valid", frame_vec_t'(out_valid), '0);
        chk("rst_frame", cur_frame(), '0);
        chk("rst_rev", cur_rev(), '0);
        chk("rst_win", cur_win(), '0);
        chk("rst_match", frame_vec_t'(out_match), '0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ir_at_release", frame_vec_t'(in_ready), '0);
        @(negedge clk);
        chk("ir_after_release", frame_vec_t'(in_ready), frame_vec_t'(1'b1));
    endtask

    // Monitor: compare a delivered frame once per rising out_valid.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (exp_frame_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got frame %h, expected none", cur_frame());
                end else begin
                    frame_vec_t ef;
                    logic       em;
                    ef = exp_frame_q.pop_front();
                    em = exp_match_q.pop_front();
                    chk("sb_frame", cur_frame(), ef);
                    chk("sb_frame_rev", cur_rev(), ef);
                    chk("sb_match", frame_vec_t'(out_match), frame_vec_t'(em));
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t fa;
        frame_vec_t fd;
        fa = ramp(8'h00);
        @(negedge clk);
        do_reset();

        // Frame 00..09 with in_valid held high.
        send_frame(fa, 1'b0, 1'b0);
        chk("frame3", frame_vec_t'(out_frame[3]), frame_vec_t'(8'h03));
        chk("rev9", frame_vec_t'(out_frame_rev[9]), frame_vec_t'(8'h00));

        // Window offsets, last one clamped.
        win_off = 4'd2; #1;
        chk("win_off2", cur_win(), frame_vec_t'(24'h040302));
        win_off = 4'd7; #1;
        chk("win_off7", cur_win(), frame_vec_t'(24'h090807));
        win_off = 4'd9; #1;
        chk("win_off9", cur_win(), frame_vec_t'(24'h090807));
        win_off = 4'd15; #1;
        chk("win_off15", cur_win(), frame_vec_t'(24'h090807));
        win_off = 4'd0;

        // Back-pressure: frame frozen, stray in_valid ignored.
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 8'hFF;
            @(negedge clk);
            chk("hold_ov", frame_vec_t'(out_valid), frame_vec_t'(1'b1));
            chk("hold_ir", frame_vec_t'(in_ready), '0);
            chk("hold_frame", cur_frame(), fa);
        end
        in_valid = 1'b0;
        deliver();

        // Equality flag.
        send_frame(fill(8'hAA), 1'b0, 1'b0);
        deliver();
        send_frame(fill(8'hAA), 1'b0, 1'b1);
        chk("match_same", frame_vec_t'(out_match), frame_vec_t'(1'b1));
        deliver();
        fd = fill(8'hAA);
        fd[(DEPTH-1)*WIDTH +: WIDTH] = 8'h55;
        send_frame(fd, 1'b0, 1'b0);
        deliver();

        // Gapped input.
        send_frame(ramp(8'h10), 1'b1, 1'b0);
        deliver();

        // Reset after 4 beats discards the partial frame.
        for (int i = 0; i < 4; i++) send_beat(8'h20 + 8'(i));
        do_reset();
        send_frame(ramp(8'h20), 1'b0, 1'b0);
        chk("frame0_after_rst", frame_vec_t'(out_frame[0]), frame_vec_t'(8'h20));
        deliver();

        // After reset prev is zero but invalid, so an all-zero frame must not match.
        do_reset();
        send_frame(fill(8'h00), 1'b0, 1'b0);
        deliver();

        repeat (3) @(negedge clk);
        chk("sb_drained", frame_vec_t'(exp_frame_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
